// File: rtl/uart_tx_path.sv
// UART transmit path: byte FIFO feeding a start/data/parity/stop/gap serializer.
// Frame configuration is captured when a byte is popped, so mid-frame edits apply to the next frame.
module uart_tx_path #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    tx_data,
    input  logic          tx_fifo_wr_en,
    input  logic          tx_fifo_rst,
    input  logic [9:0]    baud_div,
    input  logic          check,
    input  logic          parity,
    input  logic          stop_bit,
    input  logic [3:0]    two_tx_delay,
    output logic          uart_tx_o,
    output logic          tx_fifo_wfull,
    output logic [AW:0]   tx_fifo_cnt,
    output logic          tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP1,
        STOP2,
        GAP
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   cnt_reg;
    logic [AW:0]   cnt_next;
    logic          wfull_reg;
    logic          wr_accept;
    logic          pop;

    // Serializer state
    state_t        state_reg;
    logic [9:0]    bcnt_reg;
    logic [9:0]    div_reg;
    logic [2:0]    idx_reg;
    logic [3:0]    gcnt_reg;
    logic [3:0]    gap_reg;
    logic          check_reg;
    logic          parity_reg;
    logic          stop_reg;
    logic [7:0]    shreg_reg;
    logic          line_reg;
    logic          bit_end;
    logic [7:0]    par_chain;
    logic          par_bit;

    assign wr_accept = tx_fifo_wr_en && !wfull_reg && !tx_fifo_rst;
    assign pop       = (state_reg == IDLE) && (cnt_reg != '0) && !tx_fifo_rst;

    always_comb begin
        cnt_next = cnt_reg;
        case ({wr_accept, pop})
            2'b10:   cnt_next = cnt_reg + CNT_ONE;
            2'b01:   cnt_next = cnt_reg - CNT_ONE;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            cnt_reg   <= '0;
            wfull_reg <= 1'b0;
        end else if (tx_fifo_rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            cnt_reg   <= '0;
            wfull_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            cnt_reg   <= cnt_next;
            wfull_reg <= (cnt_next == CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_reg] <= tx_data;
        end
    end

    // Running XOR over the held byte; the last stage is the even-parity bit.
    assign par_chain[0] = shreg_reg[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_par
            assign par_chain[gi] = par_chain[gi-1] ^ shreg_reg[gi];
        end
    endgenerate

    assign par_bit = parity_reg ? ~par_chain[7] : par_chain[7];
    assign bit_end = (bcnt_reg == div_reg - 10'd1);

    // The line register is loaded with the level of the state being entered,
    // so each bit is exactly div_reg cycles and the output never glitches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            bcnt_reg   <= '0;
            div_reg    <= 10'd1;
            idx_reg    <= '0;
            gcnt_reg   <= '0;
            gap_reg    <= '0;
            check_reg  <= 1'b0;
            parity_reg <= 1'b0;
            stop_reg   <= 1'b0;
            shreg_reg  <= '0;
            line_reg   <= 1'b1;
        end else begin
            bcnt_reg <= ((state_reg == IDLE) || bit_end) ? 10'd0 : bcnt_reg + 10'd1;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shreg_reg  <= mem[rptr_reg];
                        div_reg    <= (baud_div == 10'd0) ? 10'd1 : baud_div;
                        check_reg  <= check;
                        parity_reg <= parity;
                        stop_reg   <= stop_bit;
                        gap_reg    <= two_tx_delay;
                        state_reg  <= START;
                        line_reg   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg <= DATA;
                        idx_reg   <= '0;
                        line_reg  <= shreg_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_reg == 3'd7) begin
                            if (check_reg) begin
                                state_reg <= PAR;
                                line_reg  <= par_bit;
                            end else begin
                                state_reg <= STOP1;
                                line_reg  <= 1'b1;
                            end
                        end else begin
                            idx_reg  <= idx_reg + 3'd1;
                            line_reg <= shreg_reg[idx_reg + 3'd1];
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state_reg <= STOP1;
                        line_reg  <= 1'b1;
                    end
                end
                STOP1: begin
                    if (bit_end) begin
                        if (stop_reg) begin
                            state_reg <= STOP2;
                        end else if (gap_reg != 4'd0) begin
                            state_reg <= GAP;
                            gcnt_reg  <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (bit_end) begin
                        if (gap_reg != 4'd0) begin
                            state_reg <= GAP;
                            gcnt_reg  <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        if (gcnt_reg == gap_reg - 4'd1) begin
                            state_reg <= IDLE;
                        end else begin
                            gcnt_reg <= gcnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    line_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx_o     = line_reg;
    assign tx_fifo_wfull = wfull_reg;
    assign tx_fifo_cnt   = cnt_reg;
    assign tx_busy       = (state_reg != IDLE);

endmodule
